muldiv_sequencer: RTL and testbench

//   Multi-cycle sequencer for RV32M ops decoded by the control unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).

---
 rtl/muldiv_sequencer_pkg.sv | 38 +++
 rtl/muldiv_sequencer_div_iter.sv | 23 ++
 rtl/muldiv_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// Shared RV32M definitions: ALU control codes, sequencer state encoding, op-class helpers.
package muldiv_sequencer_pkg;

    localparam logic [4:0] ALUCTRL_ADD    = 5'h00;
    localparam logic [4:0] ALUCTRL_MUL    = 5'h10;
    localparam logic [4:0] ALUCTRL_MULH   = 5'h11;
    localparam logic [4:0] ALUCTRL_MULHSU = 5'h12;
    localparam logic [4:0] ALUCTRL_MULHU  = 5'h13;
    localparam logic [4:0] ALUCTRL_DIV    = 5'h14;
    localparam logic [4:0] ALUCTRL_DIVU   = 5'h15;
    localparam logic [4:0] ALUCTRL_REM    = 5'h16;
    localparam logic [4:0] ALUCTRL_REMU   = 5'h17;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } mdu_state_e;

    function automatic logic is_mdu(input logic [4:0] c);
        return (c >= ALUCTRL_MUL) && (c <= ALUCTRL_REMU);
    endfunction

    function automatic logic is_div(input logic [4:0] c);
        return (c >= ALUCTRL_DIV) && (c <= ALUCTRL_REMU);
    endfunction

    function automatic logic is_sdiv(input logic [4:0] c);
        return (c == ALUCTRL_DIV) || (c == ALUCTRL_REM);
    endfunction

    function automatic logic is_rem(input logic [4:0] c);
        return (c == ALUCTRL_REM) || (c == ALUCTRL_REMU);
    endfunction

endpackage

// File: rtl/muldiv_sequencer_div_iter.sv
// One radix-2 restoring divide step on unsigned magnitudes (quotient shifts in from the LSB).
module muldiv_div_iter #(
    parameter int BITS = 32
) (
    input  logic [BITS-1:0] i_rem,
    input  logic [BITS-1:0] i_dvs,
    input  logic [BITS-1:0] i_quo,
    output logic [BITS-1:0] o_rem,
    output logic [BITS-1:0] o_quo
);

    logic [BITS:0] w_shift;
    logic [BITS:0] w_diff;
    logic          w_ge;

    // Partial remainder stays below the divisor, so bit BITS of the difference is the borrow.
    assign w_shift = {i_rem, i_quo[BITS-1]};
    assign w_diff  = w_shift - {1'b0, i_dvs};
    assign w_ge    = ~w_diff[BITS];
    assign o_rem   = w_ge ? w_diff[BITS-1:0] : w_shift[BITS-1:0];
    assign o_quo   = {i_quo[BITS-2:0], w_ge};

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle sequencer: pipelined multiply, restoring divide, stall/result handshake.
// Build option: MULDIV_EARLY_OUT_EN sends divide-by-zero / signed overflow straight to DONE.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int BITS    = 32,
    parameter int MUL_LAT = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    input  logic [4:0]      alu_ctrl,
    input  logic [BITS-1:0] rs1_data,
    input  logic [BITS-1:0] rs2_data,
    input  logic            flush,
    output logic            stall,
    output logic            res_valid,
    output logic [BITS-1:0] res_data,
    output logic            div_zero
);

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY_OUT = 1'b1;
`else
    localparam bit EARLY_OUT = 1'b0;
`endif
    localparam int CW = $clog2(((BITS > MUL_LAT) ? BITS : MUL_LAT) + 1);

    function automatic logic [BITS-1:0] mag(input logic [BITS-1:0] x, input logic sgn);
        return (sgn && x[BITS-1]) ? -x : x;
    endfunction

    // {hit, div_zero, forced result} for divide-by-zero and MIN/-1 overflow.
    function automatic logic [BITS+1:0] div_special(input logic [4:0] op,
                                                    input logic [BITS-1:0] a,
                                                    input logic [BITS-1:0] b);
        logic dz;
        logic ovf;
        logic [BITS-1:0] res;
        dz  = (b == '0);
        ovf = is_sdiv(op) && (a == {1'b1, {(BITS-1){1'b0}}}) && (b == '1);
        if (dz) res = is_rem(op) ? a : '1;
        else    res = is_rem(op) ? '0 : a;
        return {dz | ovf, dz, res};
    endfunction

    mdu_state_e          r_state;
    mdu_state_e          w_next;
    logic [CW-1:0]       r_cnt;
    logic [4:0]          r_op;
    logic [BITS-1:0]     r_a;
    logic [BITS-1:0]     r_b;
    logic [BITS-1:0]     r_rem;
    logic [BITS-1:0]     r_quo;
    logic [BITS-1:0]     r_res;
    logic                r_dz;

    logic                w_accept;
    logic                w_early;
    logic [BITS+1:0]     w_sp_in;
    logic [BITS+1:0]     w_sp_reg;
    logic [BITS-1:0]     w_dvs;
    logic [BITS-1:0]     w_rem_nxt;
    logic [BITS-1:0]     w_quo_nxt;
    logic [BITS-1:0]     w_fix_res;
    logic [BITS-1:0]     w_div_res;
    logic                w_sa;
    logic                w_sb;
    logic [2*BITS-1:0]   w_ma;
    logic [2*BITS-1:0]   w_mb;
    logic [2*BITS-1:0]   w_prod;
    logic [2*BITS-1:0]   w_prod_q;
    logic [BITS-1:0]     w_mul_res;

    assign w_accept = (r_state == S_IDLE) & req_valid & is_mdu(alu_ctrl) & ~flush;
    assign w_sp_in  = div_special(alu_ctrl, rs1_data, rs2_data);
    assign w_sp_reg = div_special(r_op, r_a, r_b);
    assign w_early  = EARLY_OUT & is_div(alu_ctrl) & w_sp_in[BITS+1];

    // Sign-extending to 2*BITS gives the same low 2*BITS bits as the (BITS+1)-bit signed product.
    assign w_sa      = (r_op == ALUCTRL_MULH) || (r_op == ALUCTRL_MULHSU);
    assign w_sb      = (r_op == ALUCTRL_MULH);
    assign w_ma      = {{BITS{w_sa & r_a[BITS-1]}}, r_a};
    assign w_mb      = {{BITS{w_sb & r_b[BITS-1]}}, r_b};
    assign w_prod    = w_ma * w_mb;
    assign w_mul_res = (r_op == ALUCTRL_MUL) ? w_prod_q[BITS-1:0] : w_prod_q[2*BITS-1:BITS];

    generate
        if (MUL_LAT == 1) begin : g_nopipe
            assign w_prod_q = w_prod;
        end else begin : g_pipe
            logic [2*BITS-1:0] r_pipe [MUL_LAT-1];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int unsigned i = 0; i < unsigned'(MUL_LAT - 1); i++) r_pipe[i] <= '0;
                end else begin
                    r_pipe[0] <= w_prod;
                    for (int unsigned i = 1; i < unsigned'(MUL_LAT - 1); i++) r_pipe[i] <= r_pipe[i-1];
                end
            end
            assign w_prod_q = r_pipe[MUL_LAT-2];
        end
    endgenerate

    assign w_dvs = mag(r_b, is_sdiv(r_op));

    muldiv_div_iter #(.BITS(BITS)) u_div_iter (
        .i_rem (r_rem),
        .i_dvs (w_dvs),
        .i_quo (r_quo),
        .o_rem (w_rem_nxt),
        .o_quo (w_quo_nxt)
    );

    always_comb begin
        w_fix_res = '0;
        if (is_rem(r_op)) w_fix_res = (is_sdiv(r_op) && r_a[BITS-1]) ? -r_rem : r_rem;
        else              w_fix_res = (is_sdiv(r_op) && (r_a[BITS-1] ^ r_b[BITS-1])) ? -r_quo : r_quo;
        w_div_res = w_sp_reg[BITS+1] ? w_sp_reg[BITS-1:0] : w_fix_res;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_accept) w_next = is_div(alu_ctrl) ? (w_early ? S_DONE : S_DIV) : S_MUL;
            S_MUL:  if (r_cnt == '0) w_next = S_DONE;
            S_DIV:  if (r_cnt == '0) w_next = S_FIX;
            S_FIX:  w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (flush) w_next = S_IDLE;
    end

    always_comb begin
        stall     = ~flush & (((r_state == S_IDLE) & w_accept) | (r_state == S_MUL)
                              | (r_state == S_DIV) | (r_state == S_FIX));
        res_valid = ~flush & (r_state == S_DONE);
        div_zero  = res_valid & r_dz;
        res_data  = r_res;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_op  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_rem <= '0;
            r_quo <= '0;
            r_res <= '0;
            r_dz  <= 1'b0;
        end else if (w_accept) begin
            r_op  <= alu_ctrl;
            r_a   <= rs1_data;
            r_b   <= rs2_data;
            r_rem <= '0;
            r_quo <= mag(rs1_data, is_sdiv(alu_ctrl));
            r_cnt <= is_div(alu_ctrl) ? CW'(BITS - 1) : CW'(MUL_LAT - 1);
            if (w_early) begin
                r_res <= w_sp_in[BITS-1:0];
                r_dz  <= w_sp_in[BITS];
            end
        end else if (!flush) begin
            unique case (r_state)
                S_MUL: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
                    else begin
                        r_res <= w_mul_res;
                        r_dz  <= 1'b0;
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
                end
                S_FIX: begin
                    r_res <= w_div_res;
                    r_dz  <= w_sp_reg[BITS];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed scoreboard bench for muldiv_sequencer (honours MULDIV_EARLY_OUT_EN for special-case latency).
module tb_muldiv_sequencer;
    import muldiv_sequencer_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int SP_LAT = 1;
`else
    localparam int SP_LAT = 34;
`endif

    typedef struct {
        logic [31:0] res;
        logic        dz;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [4:0]  alu_ctrl;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        stall;
    logic        res_valid;
    logic [31:0] res_data;
    logic        div_zero;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    muldiv_sequencer #(.BITS(32), .MUL_LAT(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .alu_ctrl  (alu_ctrl),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .flush     (flush),
        .stall     (stall),
        .res_valid (res_valid),
        .res_data  (res_data),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        req_valid = 1'b0;
        alu_ctrl  = ALUCTRL_ADD;
        rs1_data  = '0;
        rs2_data  = '0;
    endtask

    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] er, input logic edz,
                          input int elat);
        int   lat;
        logic st_ok;
        exp_t e;
        sb.push_back('{res: er, dz: edz});
        @(negedge clk);
        req_valid = 1'b1; alu_ctrl = op; rs1_data = a; rs2_data = b;
        #1 st_ok = (stall === 1'b1);
        @(posedge clk);
        #1 drive_idle();
        lat = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (res_valid === 1'b1) break;
            if (stall !== 1'b1) st_ok = 1'b0;
        end
        if (stall !== 1'b0) st_ok = 1'b0;
        chk({tag, "_lat"}, 32'(lat), 32'(elat));
        chk({tag, "_stall"}, {31'b0, st_ok}, 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_res"}, res_data, e.res);
            chk({tag, "_dz"}, {31'b0, div_zero}, {31'b0, e.dz});
        end
    endtask

    task automatic watch_quiet(input string tag, input int n);
        int hits;
        hits = 0;
        repeat (n) begin
            @(negedge clk);
            if (res_valid !== 1'b0 || stall !== 1'b0) hits++;
        end
        chk(tag, 32'(hits), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_valid", {31'b0, res_valid}, 32'd0);
        chk("rst_data", res_data, 32'd0);
        chk("rst_dz", {31'b0, div_zero}, 32'd0);
        rst_n = 1'b1;

        // non-M op is ignored
        @(negedge clk);
        req_valid = 1'b1; alu_ctrl = ALUCTRL_ADD; rs1_data = 32'd3; rs2_data = 32'd4;
        #1 chk("add_stall", {31'b0, stall}, 32'd0);
        watch_quiet("add_quiet", 4);
        drive_idle();

        run_op("mul",    ALUCTRL_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 3);
        run_op("mulhu",  ALUCTRL_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 3);
        run_op("mulhsu", ALUCTRL_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0, 3);
        run_op("mulh",   ALUCTRL_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 3);
        run_op("mulh2",  ALUCTRL_MULH,   32'h40000000, 32'h00000010, 32'h00000004, 1'b0, 3);

        run_op("div",    ALUCTRL_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 34);
        run_op("rem",    ALUCTRL_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, 34);
        run_op("div_np", ALUCTRL_DIV,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 34);
        run_op("rem_np", ALUCTRL_REM,  32'd7,        32'hFFFFFFFE, 32'h00000001, 1'b0, 34);
        run_op("divu",   ALUCTRL_DIVU, 32'd100,      32'd7,        32'd14,       1'b0, 34);
        run_op("remu",   ALUCTRL_REMU, 32'd100,      32'd7,        32'd2,        1'b0, 34);
        run_op("divu_big", ALUCTRL_DIVU, 32'hFFFFFFFF, 32'd1,      32'hFFFFFFFF, 1'b0, 34);

        run_op("divu_z", ALUCTRL_DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, SP_LAT);
        run_op("rem_z",  ALUCTRL_REM,  32'd5,        32'd0,        32'd5,        1'b1, SP_LAT);
        run_op("div_ov", ALUCTRL_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, SP_LAT);
        run_op("rem_ov", ALUCTRL_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, SP_LAT);

        // flush mid-divide at T+10
        @(negedge clk);
        req_valid = 1'b1; alu_ctrl = ALUCTRL_DIVU; rs1_data = 32'd50; rs2_data = 32'd5;
        @(posedge clk);
        #1 drive_idle();
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1 chk("flush_stall", {31'b0, stall}, 32'd0);
        chk("flush_data_kept", res_data, 32'h00000000);
        @(negedge clk);
        flush = 1'b0;
        #1 chk("flush_idle_stall", {31'b0, stall}, 32'd0);
        watch_quiet("flush_quiet", 40);
        run_op("post_flush", ALUCTRL_DIVU, 32'd9, 32'd3, 32'd3, 1'b0, 34);

        // flush and accept in the same cycle
        @(negedge clk);
        req_valid = 1'b1; alu_ctrl = ALUCTRL_MUL; rs1_data = 32'd2; rs2_data = 32'd2;
        flush = 1'b1;
        #1 chk("flush_acc_stall", {31'b0, stall}, 32'd0);
        @(posedge clk);
        #1 drive_idle();
        flush = 1'b0;
        watch_quiet("flush_acc_quiet", 8);

        // reset mid-divide
        @(negedge clk);
        req_valid = 1'b1; alu_ctrl = ALUCTRL_DIV; rs1_data = 32'd77; rs2_data = 32'd7;
        @(posedge clk);
        #1 drive_idle();
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_stall", {31'b0, stall}, 32'd0);
        chk("mrst_valid", {31'b0, res_valid}, 32'd0);
        chk("mrst_data", res_data, 32'd0);
        chk("mrst_dz", {31'b0, div_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        watch_quiet("mrst_quiet", 40);
        run_op("post_rst", ALUCTRL_DIVU, 32'd9, 32'd3, 32'd3, 1'b0, 34);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
